// File: rtl/fp_operand_loader.sv
// fp_operand_loader: byte-serial operand collector and result register for the FP32 multiplier.
// Optional partial-load idle timeout is built only when LOADER_TIMEOUT_EN is defined.
module fp_operand_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] mult_result,
   input  logic [3:0]  mult_flags,
   output logic [31:0] dataA,
   output logic [31:0] dataB,
   output logic        operands_valid,
   output logic [31:0] result,
   output logic [3:0]  flags,
   output logic        result_valid,
   output logic [2:0]  byte_count,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CAPTURE, S_DONE} state_t;

   state_t      state;
   logic [63:0] ops;
   logic [5:0]  msb;

   // Byte k lands at bits 63-8k down; 63-8k == {~k, 3'b111} for k in 0..7.
   assign msb   = {~byte_count, 3'b111};
   assign dataA = ops[63:32];
   assign dataB = ops[31:0];

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] idle_cnt;
   logic          expired;

   assign expired = (idle_cnt == IDLE_MAX);
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state          <= S_IDLE;
         ops            <= '0;
         result         <= '0;
         flags          <= '0;
         byte_count     <= '0;
         operands_valid <= 1'b0;
         result_valid   <= 1'b0;
         busy           <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
         idle_cnt       <= '0;
         timeout_err    <= 1'b0;
`endif
      end else begin
`ifdef LOADER_TIMEOUT_EN
         timeout_err <= 1'b0;
         idle_cnt    <= '0;
`endif
         case (state)
            S_IDLE: begin
               if (load) begin
                  ops[msb -: 8] <= data_in;
                  byte_count    <= 3'd1;
                  busy          <= 1'b1;
                  state         <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (load) begin
                  ops[msb -: 8] <= data_in;
                  byte_count    <= byte_count + 3'd1;
                  if (byte_count == 3'd7) begin
                     busy           <= 1'b0;
                     operands_valid <= 1'b1;
                     state          <= S_CAPTURE;
                  end
               end
`ifdef LOADER_TIMEOUT_EN
               else if (expired) begin
                  ops         <= '0;
                  byte_count  <= '0;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
`endif
            end
            S_CAPTURE: begin
               result       <= mult_result;
               flags        <= mult_flags;
               result_valid <= 1'b1;
               state        <= S_DONE;
            end
            S_DONE: begin
               // A new load starts a fresh operand pair; the old result stays visible.
               if (load) begin
                  ops            <= {data_in, 56'd0};
                  byte_count     <= 3'd1;
                  operands_valid <= 1'b0;
                  result_valid   <= 1'b0;
                  busy           <= 1'b1;
                  state          <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader: behavioural model checked every cycle plus literal spot checks.
module tb_fp_operand_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, load, clear;
   logic [7:0]  data_in;
   logic [31:0] mult_result;
   logic [3:0]  mult_flags;
   logic [31:0] dataA, dataB, result;
   logic [3:0]  flags;
   logic        operands_valid, result_valid, busy, timeout_err;
   logic [2:0]  byte_count;

   int nvec = 0;
   int nerr = 0;

   // Multiplier stand-in: exact for x*1.0 cases, flags derived from the product.
   function automatic logic [35:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [3:0]  f;
      if (a == 32'h3F800000)      r = b;
      else if (b == 32'h3F800000) r = a;
      else                        r = a ^ b;
      f[3] = (r[30:0] == 31'd0);
      f[2] = (r == 32'h7F800000);
      f[1] = (r == 32'hFF800000);
      f[0] = (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
      return {f, r};
   endfunction

   assign {mult_flags, mult_result} = fmul(dataA, dataB);

   fp_operand_loader #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load), .clear(clear),
      .mult_result(mult_result), .mult_flags(mult_flags),
      .dataA(dataA), .dataB(dataB), .operands_valid(operands_valid),
      .result(result), .flags(flags), .result_valid(result_valid),
      .byte_count(byte_count), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_n bytes gathered so far, m_age = edges since the operand pair completed (-1 = not complete).
   logic [63:0] m_ops = '0;
   logic [31:0] m_res = '0;
   logic [3:0]  m_flg = '0;
   int          m_n = 0, m_age = -1, m_idle = 0;
   bit          m_to = 1'b0, started = 1'b0;

   always @(posedge clk) begin
      m_to = 1'b0;
      if (reset || clear) begin
         m_ops = '0; m_res = '0; m_flg = '0; m_n = 0; m_age = -1; m_idle = 0;
         started = 1'b1;
      end else if (m_age == 0) begin
         {m_flg, m_res} = fmul(m_ops[63:32], m_ops[31:0]);
         m_age = 1;
      end else if (m_age == 1) begin
         if (load) begin
            m_ops = {data_in, 56'd0}; m_n = 1; m_age = -1; m_idle = 0;
         end
      end else if (load) begin
         m_ops[63-8*m_n -: 8] = data_in;
         m_n++;
         m_idle = 0;
         if (m_n == 8) begin
            m_n = 0; m_age = 0;
         end
      end else if (m_n > 0) begin
`ifdef LOADER_TIMEOUT_EN
         if (m_idle == 15) begin
            m_ops = '0; m_n = 0; m_idle = 0; m_to = 1'b1;
         end else begin
            m_idle++;
         end
`endif
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("dataA", dataA, m_ops[63:32]);
         chk("dataB", dataB, m_ops[31:0]);
         chk("byte_count", byte_count, m_n[2:0]);
         chk("busy", busy, (m_n > 0) && (m_age < 0));
         chk("operands_valid", operands_valid, m_age >= 0);
         chk("result_valid", result_valid, m_age >= 1);
         chk("result", result, m_res);
         chk("flags", flags, m_flg);
         chk("timeout_err", timeout_err, m_to);
      end
   end

   task automatic step(input bit ld, input logic [7:0] d, input bit clr);
      load = ld; data_in = d; clear = clr;
      @(posedge clk); #1;
      load = 1'b0; clear = 1'b0; data_in = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] w;
      w = {a, b};
      for (int i = 0; i < 8; i++) step(1'b1, w[63-8*i -: 8], 1'b0);
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; clear = 1'b0; data_in = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset dataA", dataA, 0);
      chk("reset byte_count", byte_count, 0);
      chk("reset result_valid", result_valid, 0);
      reset = 1'b0;

      // 1.0 x 1.0 with latency checks
      load_word(32'h3F800000, 32'h3F800000);
      chk("lat operands_valid", operands_valid, 1);
      chk("lat result_valid early", result_valid, 0);
      idle(1);
      chk("lat result_valid", result_valid, 1);
      chk("one*one result", result, 32'h3F800000);
      chk("one*one flags", flags, 4'b0000);

      // restart from done
      idle(2);
      step(1'b1, 8'h12, 1'b0);
      chk("restart dataA", dataA, 32'h12000000);
      chk("restart dataB", dataB, 0);
      chk("restart byte_count", byte_count, 1);
      chk("restart operands_valid", operands_valid, 0);
      chk("restart result_valid", result_valid, 0);
      chk("restart result kept", result, 32'h3F800000);
      step(1'b0, 8'h00, 1'b1);

      // +Inf x 1.0
      load_word(32'h7F800000, 32'h3F800000);
      idle(1);
      chk("inf result", result, 32'h7F800000);
      chk("inf flags", flags, 4'b0100);
      chk("inf dataA", dataA, 32'h7F800000);
      chk("inf dataB", dataB, 32'h3F800000);

      // 0 x 1.0, started straight from the done state
      load_word(32'h00000000, 32'h3F800000);
      idle(1);
      chk("zero result", result, 32'h00000000);
      chk("zero flags", flags, 4'b1000);

      // clear mid-load, then clear with load
      step(1'b1, 8'h40, 1'b0); step(1'b1, 8'h40, 1'b0); step(1'b1, 8'h00, 1'b0);
      chk("partial byte_count", byte_count, 3);
      chk("partial dataA", dataA, 32'h40400000);
      step(1'b0, 8'h00, 1'b1);
      chk("clear dataA", dataA, 0);
      chk("clear byte_count", byte_count, 0);
      chk("clear busy", busy, 0);
      step(1'b1, 8'h55, 1'b1);
      chk("clear+load dataA", dataA, 0);
      chk("clear+load busy", busy, 0);

      // load during the capture cycle is ignored
      load_word(32'h40000000, 32'h3F800000);
      step(1'b1, 8'hAA, 1'b0);
      chk("capture ignore byte_count", byte_count, 0);
      chk("capture ignore dataA", dataA, 32'h40000000);
      chk("capture ignore result", result, 32'h40000000);
      chk("capture ignore result_valid", result_valid, 1);

`ifdef LOADER_TIMEOUT_EN
      step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h22, 1'b0);
      idle(15);
      chk("to pre busy", busy, 1);
      chk("to pre err", timeout_err, 0);
      idle(1);
      chk("to err", timeout_err, 1);
      chk("to byte_count", byte_count, 0);
      chk("to dataA", dataA, 0);
      chk("to result kept", result, 32'h40000000);
      idle(1);
      chk("to err pulse", timeout_err, 0);
      step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h22, 1'b0);
      idle(15);
      step(1'b1, 8'h33, 1'b0);
      chk("to cancel err", timeout_err, 0);
      chk("to cancel byte_count", byte_count, 3);
      chk("to cancel dataA", dataA, 32'h11223300);
      idle(1);
      chk("to cancel busy", busy, 1);
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fp_operand_loader.md
Name: fp_operand_loader

Overview:
- Sequential front end for the FP32 multiplier unit in the ED2 practice design.
- Collects two IEEE-754 single-precision operands one byte at a time from an 8-bit switch bus, using a single-cycle load strobe.
- Presents the assembled operands to the multiplier, then registers the multiplier's result word and 4-bit special-case flags.
- Drives `operands_valid` and `result_valid` for the display stage downstream.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, number of idle cycles allowed between load strobes during a partial load (1 s at 50 MHz). Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  operand byte from the switches.
- load  input  1  single-cycle strobe (already debounced and pulsed upstream); accepts data_in.
- clear  input  1  synchronous abort/restart; same effect as reset.
- mult_result  input  32  dataR from the multiplier (combinational from dataA/dataB).
- mult_flags  input  4  casesspecial from the multiplier: {Zero, +Inf, -Inf, NaN}.
- dataA  output  32  registered operand A, to the multiplier.
- dataB  output  32  registered operand B, to the multiplier.
- operands_valid  output  1  dataA and dataB are complete.
- result  output  32  captured multiplier result.
- flags  output  4  captured special-case flags.
- result_valid  output  1  result and flags are valid.
- byte_count  output  3  index of the next byte to be loaded (0..7).
- busy  output  1  a partial load is in progress.
- timeout_err  output  1  one-cycle pulse when a partial load is aborted by timeout.

Behaviour:
- Reset, or clear at any clock edge:
  - state goes to S_IDLE.
  - dataA, dataB, result, flags, byte_count all go to 0.
  - operands_valid, result_valid, busy, timeout_err all go to 0.
  - clear has priority over load in the same cycle.
- States: S_IDLE, S_LOAD, S_CAPTURE, S_DONE.
- Byte mapping: byte k (k = byte_count) is written to {dataA,dataB}[63-8k -: 8].
  - Bytes 0..3 fill dataA MSB-first; bytes 4..7 fill dataB MSB-first.
  - Bytes not yet written keep their prior value (0 after reset/clear/restart).
- S_IDLE: on load, write byte 0, set byte_count=1, go to S_LOAD.
- S_LOAD (busy=1): on load, write byte byte_count.
  - If byte_count<7: byte_count increments.
  - If byte_count==7: byte_count wraps to 0 and state goes to S_CAPTURE.
  - No load: hold.
- S_CAPTURE (operands_valid=1, busy=0), exactly one cycle:
  - result<=mult_result, flags<=mult_flags, then go to S_DONE.
  - A load strobe arriving in this cycle is ignored.
- S_DONE (operands_valid=1, result_valid=1): outputs hold indefinitely.
  - On load: dataA and dataB are zeroed, then byte 0 is written (dataA[31:24]<=data_in, all else 0).
  - Also on that load: byte_count=1, operands_valid=0, result_valid=0, result and flags are retained, state goes to S_LOAD.
- Latency: 8th load sampled at edge N gives operands_valid=1 after N; result_valid=1 after N+1.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- The block performs no arithmetic; result and flags are exact copies of the multiplier outputs sampled in S_CAPTURE.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter of $clog2(TIMEOUT_CYCLES) bits runs only in S_LOAD and resets to 0 on every accepted load.
  - When it reaches TIMEOUT_CYCLES-1 with no load, the next edge goes to S_IDLE, zeroes dataA, dataB and byte_count, and pulses timeout_err=1 for one cycle.
  - A load in that same cycle wins: it is accepted and the timeout is cancelled.
  - result and flags are untouched by a timeout.
- Not defined: no counter is built, timeout_err is tied to 0, and S_LOAD waits indefinitely.

Test Plan:
- Load bytes 3F,80,00,00,3F,80,00,00 (1.0×1.0):
  - operands_valid rises one cycle after the 8th load, result_valid one cycle later.
  - result=0x3F800000, flags=4'b0000.
- Load 7F800000 then 3F800000 (+Inf×1.0) -> result=0x7F800000, flags=4'b0100; dataA=0x7F800000, dataB=0x3F800000.
- Load 00000000 then 3F800000 (0×1.0) -> result=0x00000000, flags=4'b1000.
- Three loads (40,40,00), then clear -> next cycle: state idle, dataA=0, byte_count=0, busy=0.
  - Also assert clear and load together: the load is ignored.
- In S_DONE, load 0x12 -> dataA=0x12000000, dataB=0, byte_count=1, operands_valid=0, result_valid=0, result unchanged.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: two loads, then 16 idle cycles -> timeout_err pulses once, byte_count=0, dataA=0.
  - Also issue a load exactly at cycle 15: it is accepted and no timeout occurs.
